// File: rtl/packet_scheduler.sv
// Arbitrates one-at-a-time send requests from a primary and a secondary FIFO to a shared packet sender.
// Define PACKET_SCHEDULER_FLUSH_EN to also flush partial packets that have aged past TIMEOUT_CYCLES.
module packet_scheduler #(
   parameter int MAX_WORDS      = 256,
   parameter int PRI_BURST      = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int ACK_WAIT       = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] pri_fill_i,
   input  logic [10:0] sec_fill_i,
   input  logic        pri_enable_i,
   input  logic        sec_enable_i,
   input  logic        sender_busy_i,
   output logic        pri_fifo_req,
   output logic        sec_fifo_req,
   output logic [8:0]  pri_packet_size_o,
   output logic [8:0]  sec_packet_size_o,
   output logic        grant_src_o,
   output logic [7:0]  ack_err_cnt_o
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLDOFF} state_t;

   localparam logic [10:0] FULL_FILL = 11'(MAX_WORDS);
   localparam logic [8:0]  FULL_SIZE = 9'(MAX_WORDS - 1);
   localparam logic [7:0]  BURST     = 8'(PRI_BURST);
   localparam logic [15:0] ACK_LAST  = 16'(ACK_WAIT - 1);

   if (MAX_WORDS < 2 || MAX_WORDS > 512 || PRI_BURST < 1 || PRI_BURST > 255 ||
       ACK_WAIT < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("packet_scheduler: parameter out of range");
   end

   state_t      state_q, state_d;
   logic        src_q, src_d;
   logic [8:0]  size_q, size_d;
   logic [7:0]  streak_q, streak_d;
   logic [15:0] ack_cnt_q, ack_cnt_d;
   logic [7:0]  err_q, err_d;
   logic        hold_q, hold_d;

   logic       pri_full, sec_full, pri_tmo, sec_tmo, pri_elig, sec_elig;
   logic       use_full, cand_pri, cand_sec, pick_sec, grant, in_flight;
   logic [8:0] pri_size, sec_size;

   assign pri_full = pri_enable_i && (pri_fill_i >= FULL_FILL);
   assign sec_full = sec_enable_i && (sec_fill_i >= FULL_FILL);

`ifdef PACKET_SCHEDULER_FLUSH_EN
   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   logic [15:0] pri_age_q, pri_age_d, sec_age_q, sec_age_d;
   logic        pri_part, sec_part;

   function automatic logic [8:0] part_size(input logic [10:0] fill);
      part_size = (fill > 11'd511) ? 9'd511 : 9'(fill[8:0] - 9'd1);
   endfunction

   assign pri_part = pri_enable_i && (pri_fill_i != '0) && (pri_fill_i < FULL_FILL);
   assign sec_part = sec_enable_i && (sec_fill_i != '0) && (sec_fill_i < FULL_FILL);
   assign pri_tmo  = pri_part && (pri_age_q >= TMO);
   assign sec_tmo  = sec_part && (sec_age_q >= TMO);
   assign pri_size = pri_full ? FULL_SIZE : part_size(pri_fill_i);
   assign sec_size = sec_full ? FULL_SIZE : part_size(sec_fill_i);

   always_comb begin
      pri_age_d = pri_age_q;
      sec_age_d = sec_age_q;
      if (!pri_part || (grant && !pick_sec)) pri_age_d = '0;
      else if (pri_age_q < TMO)              pri_age_d = pri_age_q + 16'd1;
      if (!sec_part || (grant && pick_sec))  sec_age_d = '0;
      else if (sec_age_q < TMO)              sec_age_d = sec_age_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pri_age_q <= '0;
         sec_age_q <= '0;
      end else begin
         pri_age_q <= pri_age_d;
         sec_age_q <= sec_age_d;
      end
   end
`else
   assign pri_tmo  = 1'b0;
   assign sec_tmo  = 1'b0;
   assign pri_size = FULL_SIZE;
   assign sec_size = FULL_SIZE;
`endif

   assign pri_elig = pri_full || pri_tmo;
   assign sec_elig = sec_full || sec_tmo;

   // Full-size candidates shadow timed-out partial ones; the streak rule applies within the chosen class.
   assign use_full = pri_full || sec_full;
   assign cand_pri = use_full ? pri_full : pri_tmo;
   assign cand_sec = use_full ? sec_full : sec_tmo;
   assign pick_sec = cand_sec && (!cand_pri || (streak_q == BURST));
   assign grant    = (state_q == IDLE) && !sender_busy_i && (pri_elig || sec_elig);

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      size_d    = size_q;
      streak_d  = streak_q;
      ack_cnt_d = ack_cnt_q;
      err_d     = err_q;
      hold_d    = hold_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               src_d   = pick_sec;
               size_d  = pick_sec ? sec_size : pri_size;
               state_d = ISSUE;
               if (!pick_sec && sec_elig) streak_d = (streak_q == BURST) ? streak_q : streak_q + 8'd1;
               else                       streak_d = '0;
            end
         end
         ISSUE: begin
            ack_cnt_d = '0;
            // A sender that went busy behind our back voids this slot rather than being double-booked.
            state_d   = sender_busy_i ? IDLE : WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (sender_busy_i) begin
               state_d = WAIT_DONE;
            end else if (ack_cnt_q == ACK_LAST) begin
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               hold_d  = 1'b0;
               state_d = HOLDOFF;
            end else begin
               ack_cnt_d = ack_cnt_q + 16'd1;
            end
         end
         WAIT_DONE: begin
            if (!sender_busy_i) begin
               hold_d  = 1'b0;
               state_d = HOLDOFF;
            end
         end
         HOLDOFF: begin
            hold_d = 1'b1;
            if (hold_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= 1'b0;
         size_q    <= '0;
         streak_q  <= '0;
         ack_cnt_q <= '0;
         err_q     <= '0;
         hold_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         size_q    <= size_d;
         streak_q  <= streak_d;
         ack_cnt_q <= ack_cnt_d;
         err_q     <= err_d;
         hold_q    <= hold_d;
      end
   end

   // Requests decode straight from the registered state so reset removes them with no clock.
   assign in_flight         = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
   assign pri_fifo_req      = (state_q == ISSUE) && !sender_busy_i && !src_q;
   assign sec_fifo_req      = (state_q == ISSUE) && !sender_busy_i && src_q;
   assign pri_packet_size_o = (in_flight && !src_q) ? size_q : '0;
   assign sec_packet_size_o = (in_flight && src_q) ? size_q : '0;
   assign grant_src_o       = src_q;
   assign ack_err_cnt_o     = err_q;
endmodule
